pe_mac_sequencer: RTL

- Initiator/driver for one MAC processing element (PE) that has 8 accumulators and a rounding stage.
- Accepts a valid/ready stream of Q7.9 operand pairs. Each pair is tagged with an accumulator index and a last-term flag.
- Drives the PE operand, accumulator-select and round-request pins, then collects the rounded results with their tags into a result FIFO.
- Sits between the operand buffer/scheduler and the PE array, one instance per PE.

---
 rtl/pe_mac_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_sequencer.sv
// -----------------------------------------------------------------------------
// pe_mac_sequencer
//
// Drives one MAC processing element (PE) with 8 accumulators and a rounding
// stage. Operand pairs (Q7.9, tagged with an accumulator index and a last-term
// flag) arrive on a valid/ready stream and go straight to the PE operand pins.
// A last term triggers a one-cycle round request, followed by a fixed issue
// stall. The rounded results come back on a PE strobe. They are tagged
// in order from a tag FIFO and queued in a first-word-fall-through result FIFO.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand stream handshake
//   in_a, in_b          Q operands (W bits)
//   in_idx, in_last     target accumulator, final term of its dot product
//   pe_data_in_1/2      PE operands (zero when no pair is issued)
//   pe_add_number       PE accumulator select (idx zero-extended to 4 bits)
//   pe_rounder_en       PE round request (one cycle per last term)
//   pe_keep             PE hold, tied low
//   pe_data_out         PE rounded result
//   pe_rounder_valid    PE result strobe
//   out_valid/out_ready result stream handshake
//   out_data, out_idx   rounded result and the accumulator that produced it
//   err_spurious        sticky flag: PE strobe with no round outstanding
//
// Optional feature, macro PE_MAC_SEQUENCER_STATS_EN:
//   stat_terms  [31:0]  accepted operand pairs (wrapping)
//   stat_stall  [31:0]  cycles with in_valid && !in_ready (wrapping)
//   stat_rounds [15:0]  round requests issued (wrapping)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pe_mac_sequencer #(
    parameter int para_int_bits  = 7,
    parameter int para_frac_bits = 9,
    parameter int NUM_ACC        = 8,
    parameter int ROUND_GAP      = 3,
    parameter int RES_DEPTH      = 4,
    localparam int W             = para_int_bits + para_frac_bits,
    localparam int IW            = $clog2(NUM_ACC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [IW-1:0] in_idx,
    input  logic          in_last,
    output logic [W-1:0]  pe_data_in_1,
    output logic [W-1:0]  pe_data_in_2,
    output logic [3:0]    pe_add_number,
    output logic          pe_rounder_en,
    output logic          pe_keep,
    input  logic [W-1:0]  pe_data_out,
    input  logic          pe_rounder_valid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_idx,
`ifdef PE_MAC_SEQUENCER_STATS_EN
    output logic [31:0]   stat_terms,
    output logic [31:0]   stat_stall,
    output logic [15:0]   stat_rounds,
`endif
    output logic          err_spurious
);

    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int GW = (ROUND_GAP > 1) ? $clog2(ROUND_GAP) : 1;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_ROUND,
        S_DRAIN
    } state_e;

    state_e        state_q;
    logic [GW-1:0] gap_q;
    logic [IW-1:0] idx_q;

    // Tag FIFO: one entry per round request still waiting for its PE strobe.
    logic [IW-1:0] tag_mem [RES_DEPTH];
    logic [PW-1:0] tag_wr_q, tag_rd_q;
    logic [CW-1:0] outstanding_q, outstanding_d;

    // Result FIFO, first-word-fall-through.
    logic [W-1:0]  res_data_mem [RES_DEPTH];
    logic [IW-1:0] res_idx_mem  [RES_DEPTH];
    logic [PW-1:0] res_wr_q, res_rd_q;
    logic [CW-1:0] res_count_q, res_count_d;

    logic          err_q;

    logic [CW:0]   in_use;
    logic          credit_ok;
    logic          in_fire;
    logic          tag_push;
    logic          cap_ok;
    logic          cap_spur;
    logic          res_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A round occupies a credit from its request until its result leaves the
    // result FIFO, so a strobe always finds room in the result FIFO.
    assign in_use    = {1'b0, res_count_q} + {1'b0, outstanding_q};
    assign credit_ok = in_use < (CW + 1)'(RES_DEPTH);

    assign in_ready  = !rst && (state_q == S_ISSUE) && credit_ok;
    assign in_fire   = in_valid && in_ready;
    assign tag_push  = (state_q == S_ROUND);
    assign cap_ok    = pe_rounder_valid && (outstanding_q != '0);
    assign cap_spur  = pe_rounder_valid && (outstanding_q == '0);

    assign out_valid = !rst && (res_count_q != '0);
    assign out_data  = res_data_mem[res_rd_q];
    assign out_idx   = res_idx_mem[res_rd_q];
    assign res_pop   = out_valid && out_ready;

    assign pe_keep      = 1'b0;
    assign err_spurious = err_q;

    // A round request and a result capture in the same cycle both apply.
    assign outstanding_d = outstanding_q + CW'(tag_push) - CW'(cap_ok);
    assign res_count_d   = res_count_q + CW'(cap_ok) - CW'(res_pop);

    // PE pins. With no pair issued, zero operands still target idx_q, so the
    // PE accumulates a harmless zero product.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        pe_data_in_1  = '0;
        pe_data_in_2  = '0;
        pe_add_number = 4'(idx_q);
        pe_rounder_en = 1'b0;
        if (in_fire) begin
            pe_data_in_1  = in_a;
            pe_data_in_2  = in_b;
            pe_add_number = 4'(in_idx);
        end
        if (state_q == S_ROUND) begin
            pe_rounder_en = 1'b1;
        end
        if (rst) begin
            pe_add_number = '0;
            pe_rounder_en = 1'b0;
        end
    end

    // Issue FSM: ISSUE -> (last term) ROUND -> DRAIN x ROUND_GAP -> ISSUE.
    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values, whatever order the simulator runs them in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ISSUE;
            gap_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (in_fire) begin
                        idx_q <= in_idx;
                        if (in_last) begin
                            state_q <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    state_q <= S_DRAIN;
                    gap_q   <= GW'(ROUND_GAP - 1);
                end
                S_DRAIN: begin
                    if (gap_q == '0) begin
                        state_q <= S_ISSUE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= S_ISSUE;
            endcase
        end
    end

    // FIFO pointers, occupancy and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            res_wr_q      <= '0;
            res_rd_q      <= '0;
            outstanding_q <= '0;
            res_count_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            if (tag_push) tag_wr_q <= ptr_inc(tag_wr_q);
            if (cap_ok) begin
                tag_rd_q <= ptr_inc(tag_rd_q);
                res_wr_q <= ptr_inc(res_wr_q);
            end
            if (res_pop)  res_rd_q <= ptr_inc(res_rd_q);
            outstanding_q <= outstanding_d;
            res_count_q   <= res_count_d;
            if (cap_spur) err_q <= 1'b1;
        end
    end

    // FIFO storage.
    // NOTE: storage arrays are not reset; the pointers and counts define which
    // entries are valid, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_q] <= idx_q;
        end
        if (cap_ok) begin
            res_data_mem[res_wr_q] <= pe_data_out;
            res_idx_mem[res_wr_q]  <= tag_mem[tag_rd_q];
        end
    end

`ifdef PE_MAC_SEQUENCER_STATS_EN
    logic [31:0] stat_terms_q;
    logic [31:0] stat_stall_q;
    logic [15:0] stat_rounds_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_terms_q  <= '0;
            stat_stall_q  <= '0;
            stat_rounds_q <= '0;
        end else begin
            if (in_fire)               stat_terms_q  <= stat_terms_q + 1'b1;
            if (in_valid && !in_ready) stat_stall_q  <= stat_stall_q + 1'b1;
            if (state_q == S_ROUND)    stat_rounds_q <= stat_rounds_q + 1'b1;
        end
    end

    assign stat_terms  = stat_terms_q;
    assign stat_stall  = stat_stall_q;
    assign stat_rounds = stat_rounds_q;
`endif

endmodule
